load_store_unit: RTL and testbench

Load/store unit between the RV32I execute stage and the word-organised data memory (ADDR_W-bit word address, 4-bit byte write enable, one-cycle registered read). It converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into memory accesses and returns load data aligned and extended. Misaligned accesses that cross a word are split into two consecutive accesses. Out-of-range addresses and illegal funct3 codes are reported as errors.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/load_store_unit_if.sv | 30 +++
 rtl/lsu_load_align.sv | 28 ++
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes, FSM states,
// access size decode and word-crossing detection.
package lsu_pkg;

  typedef enum logic [2:0] {
    Funct3B  = 3'b000,
    Funct3H  = 3'b001,
    Funct3W  = 3'b010,
    Funct3Bu = 3'b100,
    Funct3Hu = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    StIdle,
    StAcc0,
    StAcc1,
    StResp
  } state_e;

  // Access size in bytes; 0 for codes with no defined width.
  function automatic logic [2:0] access_size(logic [2:0] funct3);
    unique case (funct3[1:0])
      2'b00:   access_size = 3'd1;
      2'b01:   access_size = 3'd2;
      2'b10:   access_size = 3'd4;
      default: access_size = 3'd0;
    endcase
  endfunction

  // Stores have no unsigned variants, so their legal set is narrower.
  function automatic logic funct3_legal(logic we, logic [2:0] funct3);
    if (we) begin
      funct3_legal = (funct3 == Funct3B) || (funct3 == Funct3H) || (funct3 == Funct3W);
    end else begin
      funct3_legal = (funct3 == Funct3B) || (funct3 == Funct3H) || (funct3 == Funct3W) ||
                     (funct3 == Funct3Bu) || (funct3 == Funct3Hu);
    end
  endfunction

  // True when the access spills past the end of its first word.
  function automatic logic is_split(logic [2:0] size, logic [1:0] offset);
    is_split = ({2'b00, offset} + {1'b0, size}) > 4'd4;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// slave: the unit's view; master: execute stage plus memory (the environment).
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_we, mem_adr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_en, mem_we, mem_adr, mem_wdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Load result alignment: picks the addressed bytes out of the (up to two word)
// read data and sign- or zero-extends them according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] i_c,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [31:0] w_win;

  // Shift the addressed byte down to lane 0, then extend by access type.
  always_comb begin
    w_win    = 32'(i_c >> {i_offset, 3'b000});
    o_result = 32'd0;
    unique case (funct3_e'(i_funct3))
      Funct3B:  o_result = {{24{w_win[7]}}, w_win[7:0]};
      Funct3H:  o_result = {{16{w_win[15]}}, w_win[15:0]};
      Funct3W:  o_result = w_win;
      Funct3Bu: o_result = {24'd0, w_win[7:0]};
      Funct3Hu: o_result = {16'd0, w_win[15:0]};
      default:  o_result = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte-addressed requests into word memory
// accesses, splitting word-crossing accesses into two back-to-back cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);

  state_e            r_state;
  state_e            w_state_next;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_lo_word;
  logic              r_fault;

  logic              w_fault;
  logic [2:0]        w_size;
  logic [1:0]        w_off;
  logic              w_split;
  logic [7:0]        w_size_mask;
  logic [7:0]        w_mask;
  logic [31:0]       w_wdata_sized;
  logic [63:0]       w_data;
  logic [ADDR_W-1:0] w_word0;
  logic [ADDR_W-1:0] w_word1;
  logic [63:0]       w_c;
  logic [31:0]       w_load_res;

  assign w_fault = ((bus.req_addr >> (ADDR_W + 2)) != 32'd0) ||
                   !funct3_legal(bus.req_we, bus.req_funct3);

  assign w_size  = access_size(r_funct3);
  assign w_off   = r_addr[1:0];
  assign w_split = is_split(w_size, w_off);
  assign w_word0 = r_addr[ADDR_W+1:2];
  assign w_word1 = w_word0 + {{(ADDR_W - 1){1'b0}}, 1'b1};

  // Lane-position store data and byte mask across a 64-bit two-word window.
  always_comb begin
    w_size_mask   = 8'h00;
    w_wdata_sized = 32'd0;
    unique case (w_size)
      3'd1: begin
        w_size_mask   = 8'h01;
        w_wdata_sized = {24'd0, r_wdata[7:0]};
      end
      3'd2: begin
        w_size_mask   = 8'h03;
        w_wdata_sized = {16'd0, r_wdata[15:0]};
      end
      3'd4: begin
        w_size_mask   = 8'h0F;
        w_wdata_sized = r_wdata;
      end
      default: begin
        w_size_mask   = 8'h00;
        w_wdata_sized = 32'd0;
      end
    endcase
    w_mask = w_size_mask << w_off;
    w_data = {32'd0, w_wdata_sized} << {w_off, 3'b000};
  end

  // In RESP the memory holds the last-issued read; lo_word holds the first half.
  assign w_c = w_split ? {bus.mem_rdata, r_lo_word} : {32'd0, bus.mem_rdata};

  lsu_load_align u_load_align (
    .i_c      (w_c),
    .i_offset (w_off),
    .i_funct3 (r_funct3),
    .o_result (w_load_res)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request capture on accept and low-word capture during the second access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we      <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      r_fault   <= 1'b0;
      r_lo_word <= 32'd0;
    end else begin
      if (r_state == StIdle && bus.req_valid) begin
        r_we     <= bus.req_we;
        r_funct3 <= bus.req_funct3;
        r_addr   <= bus.req_addr[ADDR_W+1:0];
        r_wdata  <= bus.req_wdata;
        r_fault  <= w_fault;
      end
      if (r_state == StAcc1) begin
        r_lo_word <= bus.mem_rdata;
      end
    end
  end

  // Next-state and output decode; memory side depends only on state and latched fields.
  always_comb begin
    w_state_next   = r_state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = 32'd0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 4'b0000;
    bus.mem_adr    = '0;
    bus.mem_wdata  = 32'd0;
    unique case (r_state)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_state_next = w_fault ? StResp : StAcc0;
        end
      end
      StAcc0: begin
        bus.mem_en    = 1'b1;
        bus.mem_adr   = w_word0;
        bus.mem_we    = r_we ? w_mask[3:0] : 4'b0000;
        bus.mem_wdata = w_data[31:0];
        w_state_next  = w_split ? StAcc1 : StResp;
      end
      StAcc1: begin
        bus.mem_en    = 1'b1;
        bus.mem_adr   = w_word1;
        bus.mem_we    = r_we ? w_mask[7:4] : 4'b0000;
        bus.mem_wdata = w_data[63:32];
        w_state_next  = StResp;
      end
      StResp: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = r_fault;
        bus.resp_rdata = (r_fault || r_we) ? 32'd0 : w_load_res;
        w_state_next   = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural one-cycle-read memory.
module tb_load_store_unit;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          n_en;
    logic [11:0] adr0;
    logic [3:0]  we0;
    logic [31:0] wd0;
    logic [11:0] adr1;
    logic [3:0]  we1;
    logic [31:0] wd1;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  load_store_unit_if #(.ADDR_W(12)) bus ();

  load_store_unit #(.ADDR_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Word memory: registered read, byte-enabled write.
  logic [31:0] mem [0:4095];
  logic [31:0] mem_rdata_q;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      mem_rdata_q <= mem[bus.mem_adr];
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_we[b]) mem[bus.mem_adr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
    end
  end
  assign bus.mem_rdata = mem_rdata_q;

  vec_t        vecs [24];
  int          obs_lat;
  logic        obs_err;
  logic [31:0] obs_rdata;
  int          obs_n_en;
  logic [11:0] obs_adr [2];
  logic [3:0]  obs_we  [2];
  logic [31:0] obs_wd  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat, input logic err,
                              input logic [31:0] rdata, input int n_en,
                              input logic [11:0] adr0, input logic [3:0] we0,
                              input logic [31:0] wd0, input logic [11:0] adr1,
                              input logic [3:0] we1, input logic [31:0] wd1);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.lat = lat; v.err = err;
    v.rdata = rdata; v.n_en = n_en; v.adr0 = adr0; v.we0 = we0; v.wd0 = wd0;
    v.adr1 = adr1; v.we1 = we1; v.wd1 = wd1;
    return v;
  endfunction

  // Issue one request, then watch the memory bus and response for a bounded window.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int i;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    i = 0;
    while (!bus.req_ready && i < 10) begin
      @(negedge clk);
      i++;
    end
    obs_lat   = 0;
    obs_err   = 1'b0;
    obs_rdata = 32'd0;
    obs_n_en  = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Scramble request fields so only latched values can reach the memory bus.
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h5A5A_A5A5;
      end
      if (bus.mem_en) begin
        if (obs_n_en < 2) begin
          obs_adr[obs_n_en] = bus.mem_adr;
          obs_we[obs_n_en]  = bus.mem_we;
          obs_wd[obs_n_en]  = bus.mem_wdata;
        end
        obs_n_en++;
      end
      if (bus.resp_valid) begin
        obs_lat   = c;
        obs_err   = bus.resp_err;
        obs_rdata = bus.resp_rdata;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    issue(v.we, v.f3, v.addr, v.wdata);
    chk($sformatf("v%0d_latency", idx), 32'(obs_lat), 32'(v.lat));
    chk($sformatf("v%0d_err", idx), {31'd0, obs_err}, {31'd0, v.err});
    chk($sformatf("v%0d_rdata", idx), obs_rdata, v.rdata);
    chk($sformatf("v%0d_mem_en_cycles", idx), 32'(obs_n_en), 32'(v.n_en));
    if (v.n_en >= 1 && obs_n_en >= 1) begin
      chk($sformatf("v%0d_adr0", idx), {20'd0, obs_adr[0]}, {20'd0, v.adr0});
      chk($sformatf("v%0d_we0", idx), {28'd0, obs_we[0]}, {28'd0, v.we0});
      if (v.we) chk($sformatf("v%0d_wdata0", idx), obs_wd[0], v.wd0);
    end
    if (v.n_en >= 2 && obs_n_en >= 2) begin
      chk($sformatf("v%0d_adr1", idx), {20'd0, obs_adr[1]}, {20'd0, v.adr1});
      chk($sformatf("v%0d_we1", idx), {28'd0, obs_we[1]}, {28'd0, v.we1});
      if (v.we) chk($sformatf("v%0d_wdata1", idx), obs_wd[1], v.wd1);
    end
    @(negedge clk);
    chk($sformatf("v%0d_resp_pulse", idx), {31'd0, bus.resp_valid}, 32'd0);
    chk($sformatf("v%0d_ready_after", idx), {31'd0, bus.req_ready}, 32'd1);
    chk($sformatf("v%0d_rdata_idle", idx), bus.resp_rdata, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    reset    = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;

    //              we f3     addr          wdata        lat err rdata       n  adr0  we0  wd0
    vecs[0]  = mk(1, 3'b010, 32'h100,   32'hDEADBEEF, 2, 0, 32'h0,        1, 12'h040, 4'hF,
                  32'hDEADBEEF, 12'h0, 4'h0, 32'h0);
    vecs[1]  = mk(1, 3'b010, 32'h100,   32'h80112233, 2, 0, 32'h0,        1, 12'h040, 4'hF,
                  32'h80112233, 12'h0, 4'h0, 32'h0);
    vecs[2]  = mk(0, 3'b000, 32'h103,   32'h0,        2, 0, 32'hFFFFFF80, 1, 12'h040, 4'h0,
                  32'h0, 12'h0, 4'h0, 32'h0);
    vecs[3]  = mk(0, 3'b100, 32'h103,   32'h0,        2, 0, 32'h00000080, 1, 12'h040, 4'h0,
                  32'h0, 12'h0, 4'h0, 32'h0);
    vecs[4]  = mk(0, 3'b001, 32'h102,   32'h0,        2, 0, 32'hFFFF8011, 1, 12'h040, 4'h0,
                  32'h0, 12'h0, 4'h0, 32'h0);
    vecs[5]  = mk(0, 3'b010, 32'h100,   32'h0,        2, 0, 32'h80112233, 1, 12'h040, 4'h0,
                  32'h0, 12'h0, 4'h0, 32'h0);
    vecs[6]  = mk(1, 3'b001, 32'h103,   32'h0000ABCD, 3, 0, 32'h0,        2, 12'h040, 4'h8,
                  32'hCD000000, 12'h041, 4'h1, 32'h000000AB);
    vecs[7]  = mk(0, 3'b001, 32'h103,   32'h0,        3, 0, 32'hFFFFABCD, 2, 12'h040, 4'h0,
                  32'h0, 12'h041, 4'h0, 32'h0);
    vecs[8]  = mk(0, 3'b101, 32'h103,   32'h0,        3, 0, 32'h0000ABCD, 2, 12'h040, 4'h0,
                  32'h0, 12'h041, 4'h0, 32'h0);
    vecs[9]  = mk(1, 3'b010, 32'h101,   32'hAABBCCDD, 3, 0, 32'h0,        2, 12'h040, 4'hE,
                  32'hBBCCDD00, 12'h041, 4'h1, 32'h000000AA);
    vecs[10] = mk(0, 3'b010, 32'h101,   32'h0,        3, 0, 32'hAABBCCDD, 2, 12'h040, 4'h0,
                  32'h0, 12'h041, 4'h0, 32'h0);
    vecs[11] = mk(1, 3'b001, 32'h102,   32'h7777BEEF, 2, 0, 32'h0,        1, 12'h040, 4'hC,
                  32'hBEEF0000, 12'h0, 4'h0, 32'h0);
    vecs[12] = mk(0, 3'b101, 32'h102,   32'h0,        2, 0, 32'h0000BEEF, 1, 12'h040, 4'h0,
                  32'h0, 12'h0, 4'h0, 32'h0);
    vecs[13] = mk(1, 3'b010, 32'h3FFC,  32'h44332211, 2, 0, 32'h0,        1, 12'hFFF, 4'hF,
                  32'h44332211, 12'h0, 4'h0, 32'h0);
    vecs[14] = mk(1, 3'b010, 32'h0,     32'h88776655, 2, 0, 32'h0,        1, 12'h000, 4'hF,
                  32'h88776655, 12'h0, 4'h0, 32'h0);
    vecs[15] = mk(0, 3'b010, 32'h3FFE,  32'h0,        3, 0, 32'h66554433, 2, 12'hFFF, 4'h0,
                  32'h0, 12'h000, 4'h0, 32'h0);
    vecs[16] = mk(1, 3'b000, 32'h3FFF,  32'h12345699, 2, 0, 32'h0,        1, 12'hFFF, 4'h8,
                  32'h99000000, 12'h0, 4'h0, 32'h0);
    vecs[17] = mk(0, 3'b000, 32'h3FFF,  32'h0,        2, 0, 32'hFFFFFF99, 1, 12'hFFF, 4'h0,
                  32'h0, 12'h0, 4'h0, 32'h0);
    vecs[18] = mk(0, 3'b100, 32'h3FFF,  32'h0,        2, 0, 32'h00000099, 1, 12'hFFF, 4'h0,
                  32'h0, 12'h0, 4'h0, 32'h0);
    vecs[19] = mk(0, 3'b010, 32'h10000, 32'h0,        1, 1, 32'h0,        0, 12'h0, 4'h0,
                  32'h0, 12'h0, 4'h0, 32'h0);
    vecs[20] = mk(0, 3'b010, 32'h4000,  32'h0,        1, 1, 32'h0,        0, 12'h0, 4'h0,
                  32'h0, 12'h0, 4'h0, 32'h0);
    vecs[21] = mk(0, 3'b011, 32'h100,   32'h0,        1, 1, 32'h0,        0, 12'h0, 4'h0,
                  32'h0, 12'h0, 4'h0, 32'h0);
    vecs[22] = mk(1, 3'b100, 32'h100,   32'h11223344, 1, 1, 32'h0,        0, 12'h0, 4'h0,
                  32'h0, 12'h0, 4'h0, 32'h0);
    vecs[23] = mk(0, 3'b110, 32'h100,   32'h0,        1, 1, 32'h0,        0, 12'h0, 4'h0,
                  32'h0, 12'h0, 4'h0, 32'h0);

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_we", {28'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_adr", {20'd0, bus.mem_adr}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) run_vec(vecs[i], i);

    // Reset during the second half of a split load: no response, bus quiet at once.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h3FFE;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("mid_acc0_adr", {20'd0, bus.mem_adr}, 32'h0000_0FFF);
    @(negedge clk);
    chk("mid_acc1_en", {31'd0, bus.mem_en}, 32'd1);
    chk("mid_acc1_adr", {20'd0, bus.mem_adr}, 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("mid_rst_mem_we", {28'd0, bus.mem_we}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 1) reset = 1'b0;
      chk($sformatf("mid_rst_no_resp%0d", c), {31'd0, bus.resp_valid}, 32'd0);
    end
    // Word 0xFFF now holds 0x99332211 after the byte store above.
    run_vec(mk(0, 3'b010, 32'h3FFE, 32'h0, 3, 0, 32'h66559933, 2, 12'hFFF, 4'h0, 32'h0,
               12'h000, 4'h0, 32'h0), 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
